window_sad_matcher: RTL
=======================

WINDOW_SAD_MATCHER -- requirements
Module: window_sad_matcher

Interface
REQ-001 SHALL have parameter WIN_PER_ROW, default 64: windows delivered per image row (legal 1..128).
REQ-002 SHALL have parameter NUM_ROWS, default 64: window rows per search (legal 1..128).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  start a new search (one-cycle pulse or level).
REQ-006 SHALL have port template_data  input  [15:0][15:0][7:0]  reference patch; held stable by the source for the whole search.
REQ-007 SHALL have port window_data  input  [15:0][15:0][7:0]  candidate window, valid only while window_ready=1.
REQ-008 SHALL have port window_ready  input  1  window_data valid this cycle; source never stalls, so one may arrive every cycle.
REQ-009 SHALL have port receive  output  1  one-cycle acknowledge of an accepted window.
REQ-010 SHALL have port busy  output  1  high from search start until result_valid.
REQ-011 SHALL have port best_sad  output  16  minimum SAD found so far.
REQ-012 SHALL have port best_x, best_y  output  7 each  window column/row index of best_sad.
REQ-013 SHALL have port result_valid  output  1  one-cycle pulse when a search completes.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN; no other states are reachable.
REQ-015 IDLE: en=1 SHALL clear window counters x=0,y=0, set best_sad=16'hFFFF, best_x=best_y=0, and enter RUN next cycle; busy=1 from that cycle.
REQ-016 IDLE: window_ready SHALL be ignored (no capture, receive stays 0).
REQ-017 RUN: every cycle with window_ready=1 SHALL register window_data (stage 0) together with the current (x,y) tag; receive=1 in the following cycle, exactly once per accepted window.
REQ-018 Tag counter: x increments per accepted window; at x=WIN_PER_ROW-1, x wraps to 0 and y increments.
REQ-019 Stage 1 (cycle after capture): 16 per-row sums of |window-template| per byte, each 12 bits, unsigned, no saturation.
REQ-020 Stage 2: sum of the 16 row sums into a 16-bit SAD (max 65280, no overflow).
REQ-021 Stage 3: if SAD < best_sad (strict), best_sad, best_x, best_y SHALL update from that stage's tag; ties keep the earlier window.
REQ-022 Accept-to-best-update latency SHALL be 3 cycles; throughput one window per cycle with back-to-back window_ready.
REQ-023 RUN→DRAIN when the window tagged (WIN_PER_ROW-1, NUM_ROWS-1) is accepted; window_ready in DRAIN SHALL be ignored with receive=0.
REQ-024 DRAIN: after the last window's stage-3 compare (3 cycles after its capture), result_valid SHALL pulse 1 cycle, busy falls the same cycle, state returns to IDLE.
REQ-025 best_sad/best_x/best_y SHALL hold their values in IDLE until the next en.
REQ-026 en while in RUN or DRAIN SHALL be ignored.
REQ-027 en asserted in the same cycle result_valid pulses SHALL be ignored; a new search requires en in IDLE.
REQ-028 Gaps in window_ready SHALL not disturb pipeline ordering; bubbles carry a valid=0 flag and never update best.
REQ-029 best_sad starts at 16'hFFFF; a window with SAD=65535 is impossible, so the first window always updates.

Reset
REQ-030 rst_n=0 SHALL, asynchronously and at any time including mid-search, force state IDLE, all pipeline valid flags 0, x=y=0, receive=0, busy=0, result_valid=0, best_sad=16'hFFFF, best_x=best_y=0.
REQ-031 After rst_n rises, the block SHALL wait for en; no partial result is ever reported.

Verification
REQ-032 WIN_PER_ROW=4, NUM_ROWS=2, template all 0x10, windows all 0x10 except window 5 all 0x12 -> best_sad=0, best_x=0, best_y=0 (tie keeps first), result_valid 3 cycles after 8th capture.
REQ-033 Same params, window 6 (x=2,y=1) identical to template, others differ by 1 per byte -> best_sad=0, best_x=2, best_y=1; others' SAD=256 never win.
REQ-034 Template all 0x00, single window all 0xFF -> best_sad=65280, no overflow.
REQ-035 8 back-to-back window_ready cycles then 4 extra pulses in DRAIN -> exactly 8 receive pulses, extra windows ignored.
REQ-036 Assert rst_n=0 after 3 of 8 windows -> outputs at reset values immediately; next en plus 8 windows yields a correct result from only those 8.
REQ-037 window_ready with 1-cycle gaps, and en pulsed during RUN -> result identical to back-to-back case, search not restarted.

Source files
------------

// File: rtl/window_sad_matcher_if.sv
// rtl/window_sad_matcher_if.sv - handshake and result bundle for the SAD window matcher
interface window_sad_matcher_if;
  logic                    en;
  logic [15:0][15:0][7:0]  template_data;
  logic [15:0][15:0][7:0]  window_data;
  logic                    window_ready;
  logic                    receive;
  logic                    busy;
  logic [15:0]             best_sad;
  logic [6:0]              best_x;
  logic [6:0]              best_y;
  logic                    result_valid;

  modport master (
    output en, template_data, window_data, window_ready,
    input  receive, busy, best_sad, best_x, best_y, result_valid
  );

  modport slave (
    input  en, template_data, window_data, window_ready,
    output receive, busy, best_sad, best_x, best_y, result_valid
  );
endinterface

// File: rtl/window_sad_matcher.sv
// rtl/window_sad_matcher.sv - pipelined 16x16 SAD search keeping the best window position
module window_sad_matcher #(
  parameter int WIN_PER_ROW = 64,
  parameter int NUM_ROWS    = 64
) (
  input logic               clk,
  input logic               rst_n,
  window_sad_matcher_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [6:0] X_LAST = 7'(WIN_PER_ROW - 1);
  localparam logic [6:0] Y_LAST = 7'(NUM_ROWS - 1);

  logic [1:0]             state;
  logic [6:0]             x_cnt;
  logic [6:0]             y_cnt;

  // stage 0: captured window and its tag
  logic                   s0_valid;
  logic                   s0_last;
  logic [6:0]             s0_x;
  logic [6:0]             s0_y;
  logic [15:0][15:0][7:0] s0_win;

  // stage 1: per-row absolute-difference sums
  logic                   s1_valid;
  logic                   s1_last;
  logic [6:0]             s1_x;
  logic [6:0]             s1_y;
  logic [15:0][11:0]      s1_rows;

  // stage 2: full-window SAD
  logic                   s2_valid;
  logic                   s2_last;
  logic [6:0]             s2_x;
  logic [6:0]             s2_y;
  logic [15:0]            s2_sad;

  logic                   receive_q;
  logic                   busy_q;
  logic                   result_valid_q;
  logic [15:0]            best_sad_q;
  logic [6:0]             best_x_q;
  logic [6:0]             best_y_q;

  logic [15:0][11:0]      row_sum_c;
  logic [15:0]            sad_c;
  logic                   accept;
  logic                   tag_last;

  assign accept   = (state == S_RUN) && bus.window_ready;
  assign tag_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  assign bus.receive      = receive_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.best_sad     = best_sad_q;
  assign bus.best_x       = best_x_q;
  assign bus.best_y       = best_y_q;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Row sums of |window - template|; 16 x 255 fits in 12 bits so no clamp is needed.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < 16; c++) begin
        row_sum_c[r] = row_sum_c[r] + 12'(abs_diff(s0_win[r][c], bus.template_data[r][c]));
      end
    end
  end

  // Total of the row sums; 16 x 4080 = 65280 fits in 16 bits.
  always_comb begin
    sad_c = '0;
    for (int r = 0; r < 16; r++) begin
      sad_c = sad_c + 16'(s1_rows[r]);
    end
  end

  // Datapath payload moves every cycle; its meaning is qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_win <= bus.window_data;
      s0_x   <= x_cnt;
      s0_y   <= y_cnt;
    end
    s1_rows <= row_sum_c;
    s1_x    <= s0_x;
    s1_y    <= s0_y;
    s2_sad  <= sad_c;
    s2_x    <= s1_x;
    s2_y    <= s1_y;
  end

  // Search control, valid/last flags, tag counter and best-match tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      s0_valid       <= 1'b0;
      s0_last        <= 1'b0;
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      s2_valid       <= 1'b0;
      s2_last        <= 1'b0;
      receive_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      best_sad_q     <= 16'hFFFF;
      best_x_q       <= '0;
      best_y_q       <= '0;
    end else begin
      receive_q      <= 1'b0;
      result_valid_q <= 1'b0;
      s0_valid       <= accept;
      s0_last        <= accept && tag_last;
      s1_valid       <= s0_valid;
      s1_last        <= s0_last;
      s2_valid       <= s1_valid;
      s2_last        <= s1_last;

      // Strict less-than: on a tie the earlier window stays the winner.
      if (s2_valid && (s2_sad < best_sad_q)) begin
        best_sad_q <= s2_sad;
        best_x_q   <= s2_x;
        best_y_q   <= s2_y;
      end

      case (state)
        S_IDLE: begin
          // An en coinciding with the completion pulse does not start a search.
          if (bus.en && !result_valid_q) begin
            state      <= S_RUN;
            busy_q     <= 1'b1;
            x_cnt      <= '0;
            y_cnt      <= '0;
            best_sad_q <= 16'hFFFF;
            best_x_q   <= '0;
            best_y_q   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            receive_q <= 1'b1;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + 7'd1;
            end else begin
              x_cnt <= x_cnt + 7'd1;
            end
            if (tag_last) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last window is being compared on this edge.
          if (s2_valid && s2_last) begin
            state          <= S_IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
